// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes,
// R-type funct codes, ALU control codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_alu_decode.sv
// Combinational R-type funct decoder: latched funct -> ALU control code plus
// a flag telling the FSM whether the funct is one it supports.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_valid
);

  always_comb begin
    alu_op      = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM producing all datapath strobes from op/funct.
// Optional MC_INSTR_COUNT_EN adds a retired-instruction counter output.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
`ifdef MC_INSTR_COUNT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_code,
  input  logic [5:0] func_code,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
`ifdef MC_INSTR_COUNT_EN
  ,
  output logic [CNT_W-1:0] instr_count
`endif
);

  state_t     state_q, state_d;
  logic [5:0] op_q, funct_q;
  logic [2:0] dec_alu_op;
  logic       dec_valid;

  mc_alu_decode u_alu_decode (
    .funct       (funct_q),
    .alu_op      (dec_alu_op),
    .funct_valid (dec_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q    <= op_code;
        funct_q <= func_code;
      end
    end
  end

  // DECODE dispatches on the live op_code because the latch updates at the end of that cycle.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALU;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (op_code)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_I_EXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = dec_alu_op;
        state_d   = dec_valid ? S_R_WB : S_ILLEGAL;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_SUB;
        pc_src     = PC_ALUOUT;
        pc_write   = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        alu_op  = 3'b000;
        state_d = S_FETCH;
      end
    endcase
  end

  assign state = state_q;

`ifdef MC_INSTR_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else if (instr_done) count_q <= count_q + 1'b1;
  end

  assign instr_count = count_q;
`endif

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle control unit for the datapath. It takes the op_code/func_code fields driven from the instruction register and produces every per-cycle datapath control strobe, including the 3-bit ALU control code. It sits between the instruction register and the datapath muxes, register file, ALU and memory port. It is the consumer/decoder side of the op/funct field selection used by the ALU control path.

Parameters:
CNT_W, 32, width of the optional retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
op_code  in  6  instruction [31:26] from instruction register
func_code  in  6  instruction [5:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  PC load enable
ir_write  out  1  instruction register load enable
mem_read  out  1  memory read request
mem_write  out  1  memory write request
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
reg_write  out  1  register file write enable
reg_dst  out  1  write register select: 0=rt, 1=rd
mem_to_reg  out  1  write-back data select: 0=ALUOut, 1=MDR
alu_src_a  out  1  ALU A select: 0=PC, 1=rs
alu_src_b  out  2  ALU B select: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  3  ALU control code
pc_src  out  2  PC source select: 00=ALU result, 01=ALUOut, 10=jump target
illegal  out  1  one-cycle pulse on an undecodable instruction
instr_done  out  1  one-cycle pulse in the final state of each instruction
state  out  4  current state (debug)

Behaviour:
- Reset:
  - Asynchronous; state goes to IDLE (0).
  - In IDLE all outputs are 0 and alu_op = 3'b010.
  - The cycle after reset deasserts, the FSM moves to FETCH.
  - Reset asserted mid-instruction aborts it immediately; no further strobes.
- ALU codes: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- Supported instructions:
  - R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- Outputs are Moore, decoded from state plus the latched op/funct. The only exceptions are pc_write in FETCH and BRANCH, and the handshake-qualified strobes.
- States and transitions:
  - FETCH (1): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00. Holds while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - DECODE (2): latch op_code/func_code into internal registers. alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target). Dispatch on op:
    - lw/sw -> MEM_ADDR
    - R-type -> R_EXEC
    - beq -> BRANCH
    - addi -> I_EXEC
    - j -> JUMP
    - anything else -> ILLEGAL
  - MEM_ADDR (3): alu_src_a=1, alu_src_b=10, alu_op=ADD. lw -> MEM_RD; sw -> MEM_WR.
  - MEM_RD (4): mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
  - MEM_WB (5): reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Goes to FETCH.
  - MEM_WR (6): mem_write=1, i_or_d=1. Holds until mem_ready. On the mem_ready cycle instr_done=1 and the FSM goes to FETCH. mem_write stays high for every waiting cycle.
  - R_EXEC (7): alu_src_a=1, alu_src_b=00, alu_op from the latched funct. An unsupported funct goes to ILLEGAL instead of R_WB.
  - R_WB (8): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Goes to FETCH.
  - BRANCH (9): alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01, pc_write=zero, instr_done=1. Goes to FETCH.
  - I_EXEC (10): alu_src_a=1, alu_src_b=10, alu_op=ADD. Goes to I_WB.
  - I_WB (11): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
  - JUMP (12): pc_src=10, pc_write=1, instr_done=1. Goes to FETCH.
  - ILLEGAL (13): illegal=1 and no write strobes. Goes to FETCH; the instruction is skipped because PC was already incremented.
- Latency with mem_ready tied 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal 3 cycles (4 if the funct is bad).
- Each cycle mem_ready stays low in a waiting state adds exactly one cycle.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- mem_read and mem_write are never both high.
- op/funct input changes after DECODE have no effect on the current instruction.
- Unused state encodings (0xE, 0xF) go to FETCH next cycle with all outputs 0.

Optional Feature:
MC_INSTR_COUNT_EN:
- Defined: adds output instr_count[CNT_W-1:0]. It is cleared by reset and increments on each instr_done cycle, wrapping modulo 2^CNT_W. Illegal instructions are not counted.
- Undefined: no port and no counter logic.

Decomposition:
- Package mc_ctrl_pkg: state encoding constants, opcode constants, funct constants, ALU code constants, alu_src_b and pc_src encodings.
- One sub-module, mc_alu_decode: combinational latched funct -> {alu_op, funct_valid}, instantiated for R_EXEC.

Test Plan:
- Reset held 3 cycles then released, mem_ready=1 -> IDLE with all outputs 0 and alu_op=010; FETCH next cycle with mem_read=1 and pc_write=1.
- op=0x00, funct=0x22, mem_ready=1 -> states 1,2,7,8. alu_op=110 in R_EXEC; reg_write=1, reg_dst=1 in R_WB; instr_done on cycle 4.
- lw (op=0x23) with mem_ready low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles, mem_read and i_or_d high throughout; MEM_WB has reg_write=1, mem_to_reg=1; total 7 cycles.
- beq (op=0x04) with zero=1 and again with zero=0 -> BRANCH pc_write=1 with pc_src=01 in the first case, pc_write=0 in the second; both take 3 cycles.
- op=0x3F, then op=0x00 with funct=0x03 -> illegal pulse in state 13, no reg_write or mem_write, return to FETCH.
- Reset asserted asynchronously mid-MEM_WR -> mem_write drops without a clock edge and state=0. With MC_INSTR_COUNT_EN, instr_count=0 after reset and equals 5 after 5 legal instructions.
